// File: rtl/ysyx_22040931_mdu_seq.sv
// ysyx_22040931_mdu_seq: multi-cycle RV64M sequencer (shift-add multiply, restoring divide, one bit per cycle)
module ysyx_22040931_mdu_seq #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  mdu_op,
  input  logic [XLEN-1:0] num1,
  input  logic [XLEN-1:0] num2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic r_w, r_div, r_rem, r_hi, r_neg;
  logic [5:0] r_cnt;
  logic [63:0] r_x, r_out;
  logic [127:0] r_y, r_acc;
  logic w_iw, w_idiv, w_irem, w_s1, w_s2, w_ill, w_n1, w_n2, w_zero, w_ovf, w_spec, w_accept;
  logic [63:0] w_e1, w_e2, w_m1, w_m2, w_r1, w_sres;
  assign w_iw   = (mdu_op >= 4'd8) && (mdu_op <= 4'd12);
  assign w_idiv = (mdu_op[3:2] == 2'b01) || ((mdu_op >= 4'd9) && (mdu_op <= 4'd12));
  assign w_irem = (mdu_op == 4'd6) || (mdu_op == 4'd7) || (mdu_op == 4'd11) || (mdu_op == 4'd12);
  assign w_s1   = (mdu_op == 4'd1) || (mdu_op == 4'd2) || (mdu_op == 4'd4) || (mdu_op == 4'd6) || (mdu_op == 4'd9) || (mdu_op == 4'd11);
  assign w_s2   = w_s1 && (mdu_op != 4'd2);
  assign w_ill  = mdu_op >= 4'd13;
  assign w_e1   = w_iw ? {{32{w_s1 & num1[31]}}, num1[31:0]} : num1;
  assign w_e2   = w_iw ? {{32{w_s2 & num2[31]}}, num2[31:0]} : num2;
  assign w_r1   = {w_iw ? {32{num1[31]}} : num1[63:32], num1[31:0]};
  assign w_n1   = w_s1 & w_e1[63];
  assign w_n2   = w_s2 & w_e2[63];
  assign w_m1   = w_n1 ? -w_e1 : w_e1;
  assign w_m2   = w_n2 ? -w_e2 : w_e2;
  assign w_zero = w_idiv && (w_e2 == 64'd0);
  assign w_ovf  = w_idiv && w_s1 && (w_e1 == {w_iw ? 33'h1_FFFF_FFFF : 33'h1_0000_0000, 31'd0}) && (w_e2 == {64{1'b1}});
  assign w_spec = w_zero || w_ovf || w_ill;
  // Overflow quotient equals the (width-extended) dividend itself.
  assign w_sres = w_ill ? 64'd0 : w_zero ? (w_irem ? w_r1 : {64{1'b1}}) : (w_irem ? 64'd0 : w_r1);
  assign w_accept = (r_state == IDLE) && in_valid && !flush;
  logic [64:0] w_sh;
  logic [63:0] w_dif, w_x_n, w_dv, w_dn, w_lo, w_res;
  logic [127:0] w_acc_n, w_y_n, w_p;
  logic w_ge, w_last;
  assign w_sh    = {r_acc[63:0], r_x[63]};
  assign w_ge    = w_sh >= {1'b0, r_y[63:0]};
  assign w_dif   = w_sh[63:0] - r_y[63:0];
  assign w_acc_n = r_div ? {64'd0, w_ge ? w_dif : w_sh[63:0]} : r_acc + (r_x[0] ? r_y : 128'd0);
  assign w_x_n   = r_div ? {r_x[62:0], w_ge} : {1'b0, r_x[63:1]};
  assign w_y_n   = r_div ? r_y : {r_y[126:0], 1'b0};
  assign w_last  = r_cnt == {~r_w, 5'h1f};
  assign w_p     = r_neg ? -w_acc_n : w_acc_n;
  assign w_dv    = r_rem ? w_acc_n[63:0] : w_x_n;
  assign w_dn    = r_neg ? -w_dv : w_dv;
  assign w_lo    = r_div ? w_dn : w_p[63:0];
  assign w_res   = r_hi ? w_p[127:64] : r_w ? {{32{w_lo[31]}}, w_lo[31:0]} : w_lo;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (flush) w_next = IDLE;
    else if (r_state == IDLE) w_next = in_valid ? (w_spec ? DONE : CALC) : IDLE;
    else if (r_state == CALC) w_next = w_last ? DONE : CALC;
    else w_next = out_ready ? IDLE : DONE;
  end
  // W divides park the dividend in the top half so the MSB feed is width-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_w, r_div, r_rem, r_hi, r_neg} <= '0;
      r_cnt <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
      r_out <= '0;
    end else if (w_accept) begin
      r_w   <= w_iw;
      r_div <= w_idiv;
      r_rem <= w_irem;
      r_hi  <= (mdu_op != 4'd0) && (mdu_op <= 4'd3);
      r_neg <= w_irem ? w_n1 : w_n1 ^ w_n2;
      r_cnt <= '0;
      r_x   <= w_idiv ? (w_iw ? {w_m1[31:0], 32'd0} : w_m1) : w_m2;
      r_y   <= {64'd0, w_idiv ? w_m2 : w_m1};
      r_acc <= '0;
      r_out <= w_sres;
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + 6'd1;
      r_x   <= w_x_n;
      r_y   <= w_y_n;
      r_acc <= w_acc_n;
      if (w_last) r_out <= w_res;
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign out       = r_out;
endmodule

// File: tb/tb_ysyx_22040931_mdu_seq.sv
// tb_ysyx_22040931_mdu_seq: randomized scoreboard bench with an arithmetic reference model
module tb_ysyx_22040931_mdu_seq;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [3:0] mdu_op = 0;
  logic [63:0] num1 = 0, num2 = 0;
  logic in_ready, out_valid, busy;
  logic [63:0] out;
  int cyc = 0, total = 0, bad = 0;
  bit force_en = 1, force_val = 1, seen = 0;
  logic [63:0] held;
  typedef struct {logic [63:0] res; int cyc;} exp_t;
  exp_t q[$];
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  ysyx_22040931_mdu_seq dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mdu_op(mdu_op), .num1(num1), .num2(num2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0] a32, b32;
    a32 = a[31:0];
    b32 = b[31:0];
    case (op)
      4'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
      4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
      4'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      4'd4: return b == 0 ? ONES : (a == MIN && b == ONES) ? a : 64'($signed(a) / $signed(b));
      4'd5: return b == 0 ? ONES : a / b;
      4'd6: return b == 0 ? a : (a == MIN && b == ONES) ? 64'd0 : 64'($signed(a) % $signed(b));
      4'd7: return b == 0 ? a : a % b;
      4'd8: return sx32(a32 * b32);
      4'd9: return b32 == 0 ? ONES : (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? sx32(a32) : sx32(32'($signed(a32) / $signed(b32)));
      4'd10: return b32 == 0 ? ONES : sx32(a32 / b32);
      4'd11: return b32 == 0 ? sx32(a32) : (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? 64'd0 : sx32(32'($signed(a32) % $signed(b32)));
      4'd12: return b32 == 0 ? sx32(a32) : sx32(a32 % b32);
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit special(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op >= 13) return 1;
    if (op >= 4 && op <= 7) return b == 0 || ((op == 4 || op == 6) && a == MIN && b == ONES);
    if (op >= 9 && op <= 12) return b[31:0] == 0 || ((op == 9 || op == 11) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return 0;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input bit push, output int waits);
    mdu_op = op; num1 = a; num2 = b; in_valid = 1; waits = 0;
    do begin @(negedge clk); waits++; end while (!in_ready && waits < 400);
    if (!in_ready) begin
      chk("accept_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 0;
      return;
    end
    @(posedge clk); #1;
    if (push) q.push_back('{res, cyc + (special(op, a, b) ? 0 : ((op >= 8 && op <= 12) ? 32 : 64))});
    in_valid = 0; num1 = {$urandom, $urandom}; num2 = {$urandom, $urandom}; mdu_op = 4'($urandom);
  endtask

  task automatic go(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] res);
    int w;
    issue(op, a, b, res, 1, w);
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (q.size() > 0 || busy); i++) @(negedge clk);
    chk("drain_pending", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MIN;
      3: return 64'($urandom_range(0, 20));
      4: return sx32($urandom);
      5: return 64'h0000_0000_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial forever begin
    @(posedge clk); #2;
    out_ready = force_en ? force_val : ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin
    if (rst) seen = 0;
    else if (out_valid) begin
      if (!seen) begin
        if (q.size() == 0) chk("spurious_valid", {63'd0, out_valid}, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("result", out, e.res);
          chk("latency_cycle", 64'(cyc), 64'(e.cyc));
        end
        held = out;
        seen = 1;
      end else chk("hold", out, held);
      if (out_ready) seen = 0;
    end
  end

  initial begin
    int w;
    logic [3:0] op;
    logic [63:0] a, b;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out", out, 64'd0);
    @(posedge clk); #1;
    go(4'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
    go(4'd4, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    go(4'd6, -64'sd7, 64'd2, ONES);
    go(4'd5, 64'd12345, 64'd0, ONES);
    go(4'd4, MIN, ONES, MIN);
    go(4'd6, MIN, ONES, 64'd0);
    go(4'd12, 64'h0000_0000_8000_0007, 64'h10, 64'd7);
    go(4'd10, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    go(4'd11, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0);
    go(4'd7, 64'hDEAD_BEEF, 64'd0, 64'hDEAD_BEEF);
    go(4'd14, 64'd5, 64'd6, 64'd0);
    drain();
    force_val = 0;
    go(4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk); #1;
    force_val = 1;
    issue(4'd5, 64'd100, 64'd7, 64'd14, 1, w);
    chk("same_cycle_accept_delay", 64'(w), 64'd2);
    drain();
    issue(4'd4, {$urandom, $urandom}, 64'd3, 64'd0, 0, w);
    repeat (19) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (80) @(posedge clk);
    #1;
    go(4'd5, 64'd100, 64'd7, 64'd14);
    drain();
    flush = 1; in_valid = 1; mdu_op = 4'd5; num1 = 64'd9; num2 = 64'd0;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_idle_no_accept", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    issue(4'd1, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 0, w);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out", out, 64'd0);
    @(posedge clk); #1;
    force_en = 0;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      go(op, a, b, model(op, a, b));
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
